osc_gen: RTL and testbench
==========================

OSC_GEN -- requirements
Module: osc_gen

Interface
REQ-001 SHALL have parameter TW, default 32, meaning the width of all time quantities (unsigned, units of emulator time LSB).
REQ-002 SHALL have parameter INIT_HI, default 0, meaning the clk_o level after reset (0 = low phase first).
REQ-003 SHALL have port clk_i, input, 1, the emulator clock, one clock for the whole block; all state rising-edge.
REQ-004 SHALL have port rst_ni, input, 1, the reset, asynchronous and active-low.
REQ-005 SHALL have port en_i, input, 1, run enable; when low, time does not advance and dt_req_o = all-ones.
REQ-006 SHALL have port t_lo_i, input, TW, the requested low-phase duration.
REQ-007 SHALL have port t_hi_i, input, TW, the requested high-phase duration.
REQ-008 SHALL have port dt_req_o, input... correction: output, TW, the time remaining until the next clk_o edge (timestep request to the time manager).
REQ-009 SHALL have port dt_i, input, TW, the timestep granted for the current emulator cycle.
REQ-010 SHALL have port clk_o, output, 1, the generated emulated clock level.
REQ-011 SHALL have port rise_o, output, 1, a one-cycle strobe in the cycle clk_o goes 0->1.
REQ-012 SHALL have port fall_o, output, 1, a one-cycle strobe in the cycle clk_o goes 1->0.
REQ-013 SHALL have port err_o, output, 1, sticky overrun flag.

Function
REQ-014 SHALL hold state phase (LO/HI) and a remaining-time register rem (TW bits); clk_o = (phase == HI), registered.
REQ-015 SHALL drive dt_req_o = rem combinationally when en_i is high.
REQ-016 Each clk_i edge with en_i high and dt_i < rem SHALL set rem <= rem - dt_i with phase unchanged.
REQ-017 Each clk_i edge with en_i high and dt_i == rem SHALL toggle phase, pulse rise_o or fall_o in that same registered cycle, and load rem with the new phase's duration.
REQ-018 Durations SHALL be sampled from t_lo_i/t_hi_i only at the toggle edge (or at reset release); mid-phase input changes take effect at the next edge only.
REQ-019 A sampled duration of 0 SHALL be clamped to 1, so a phase never lasts zero time.
REQ-020 dt_i > rem with en_i high SHALL set err_o (sticky until reset) and SHALL be treated as dt_i == rem (toggle once; no multiple toggles per cycle).
REQ-021 dt_i == 0 SHALL leave all state unchanged.
REQ-022 en_i low SHALL freeze phase, rem, and clk_o, and hold rise_o/fall_o low.
REQ-023 Latency: the toggle SHALL be visible on clk_o one clk_i cycle after the granting edge, with rise_o/fall_o aligned to clk_o.

Reset
REQ-024 While rst_ni is low, outputs SHALL be: clk_o = INIT_HI, rise_o = 0, fall_o = 0, err_o = 0, and phase = INIT_HI.
REQ-025 While rst_ni is low, rem SHALL hold all-ones; at the first enabled edge after release, rem SHALL load the duration of the current phase before counting.
REQ-026 Reset assertion mid-phase SHALL discard rem and the sampled durations immediately, without regard to clk_i.

Configuration
REQ-027 With macro OSC_GEN_CNT_EN defined, the block SHALL add output cyc_cnt_o (32 bits, reset 0), incrementing on every rise_o and wrapping from 2^32-1 to 0.
REQ-028 Without OSC_GEN_CNT_EN, the cyc_cnt_o port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Bench SHALL drive t_lo=3, t_hi=5, dt_i=dt_req_o every cycle, and check that clk_o alternates every cycle and dt_req_o sequence is 3,5,3,5.
REQ-030 Bench SHALL drive t_lo=3, t_hi=5, dt_i=1 constantly, and check clk_o low 3 cycles then high 5 cycles, repeating, with one rise_o and one fall_o per period.
REQ-031 Bench SHALL change t_hi from 5 to 2 in the middle of a high phase, and check that the current high phase still lasts 5 and the next lasts 2.
REQ-032 Bench SHALL set rem=4 and drive dt_i=7, and check err_o=1 thereafter, a single toggle, and rem reloaded.
REQ-033 Bench SHALL set t_lo=0 and check that the low phase lasts 1 and dt_req_o=1.
REQ-034 Bench SHALL assert rst_ni mid-phase for one cycle, and check immediate return to the reset values; with OSC_GEN_CNT_EN, it SHALL also check that after 10 periods cyc_cnt_o=10 and that cyc_cnt_o is 0 after reset.

Source files
------------

// File: rtl/osc_gen.sv
// Emulated clock generator: counts granted emulator timesteps against programmable low/high phase durations.
// Optional build macro OSC_GEN_CNT_EN adds a 32-bit rising-edge counter output cyc_cnt_o.
module osc_gen #(
    parameter int TW      = 32,
    parameter int INIT_HI = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [TW-1:0] t_lo_i,
    input  logic [TW-1:0] t_hi_i,
    output logic [TW-1:0] dt_req_o,
    input  logic [TW-1:0] dt_i,
    output logic          clk_o,
    output logic          rise_o,
    output logic          fall_o,
    output logic          err_o
`ifdef OSC_GEN_CNT_EN
    ,
    output logic [31:0]   cyc_cnt_o
`endif
);

    typedef enum logic {
        LO = 1'b0,
        HI = 1'b1
    } phase_t;

    localparam phase_t RST_PHASE = (INIT_HI != 0) ? HI : LO;

    phase_t        phase;
    phase_t        next_phase;
    logic [TW-1:0] rem;
    logic          loaded;
    logic [TW-1:0] lo_dur;
    logic [TW-1:0] hi_dur;
    logic [TW-1:0] cur_dur;
    logic [TW-1:0] next_dur;
    logic          toggle;

    // A zero duration is clamped to one so a phase never lasts zero time.
    assign lo_dur     = (t_lo_i == '0) ? TW'(1) : t_lo_i;
    assign hi_dur     = (t_hi_i == '0) ? TW'(1) : t_hi_i;
    assign next_phase = (phase == HI) ? LO : HI;
    assign cur_dur    = (phase == HI) ? hi_dur : lo_dur;
    assign next_dur   = (next_phase == HI) ? hi_dur : lo_dur;

    // An overrun grant (dt_i > rem) is handled as an exact hit: one toggle only.
    assign toggle = en_i && loaded && (dt_i != '0) && (dt_i >= rem);

    assign dt_req_o = en_i ? rem : '1;
    assign clk_o    = (phase == HI);

    // rem is meaningless until the first enabled edge after reset loads it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase  <= RST_PHASE;
            rem    <= '1;
            loaded <= 1'b0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (en_i) begin
                if (!loaded) begin
                    rem    <= cur_dur;
                    loaded <= 1'b1;
                end else if (toggle) begin
                    if (dt_i > rem) begin
                        err_o <= 1'b1;
                    end
                    phase  <= next_phase;
                    rem    <= next_dur;
                    rise_o <= (next_phase == HI);
                    fall_o <= (next_phase == LO);
                end else if (dt_i != '0) begin
                    rem <= rem - dt_i;
                end
            end
        end
    end

`ifdef OSC_GEN_CNT_EN
    // Counts at the same edge that raises rise_o, so the count and strobe line up.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_cnt_o <= '0;
        end else if (toggle && (next_phase == HI)) begin
            cyc_cnt_o <= cyc_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_osc_gen.sv
// Directed self-checking bench for osc_gen (TW=32, INIT_HI=0).
// Define OSC_GEN_CNT_EN to also exercise the rising-edge counter.
module tb_osc_gen;

    logic        clk_i;
    logic        rst_ni;
    logic        en_i;
    logic [31:0] t_lo_i;
    logic [31:0] t_hi_i;
    logic [31:0] dt_req_o;
    logic [31:0] dt_i;
    logic        clk_o;
    logic        rise_o;
    logic        fall_o;
    logic        err_o;
    logic        follow;
    logic [31:0] dt_drive;
`ifdef OSC_GEN_CNT_EN
    logic [31:0] cyc_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    // Follow mode grants exactly the requested step, so every edge toggles.
    assign dt_i = follow ? dt_req_o : dt_drive;

    osc_gen #(
        .TW     (32),
        .INIT_HI(0)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en_i),
        .t_lo_i   (t_lo_i),
        .t_hi_i   (t_hi_i),
        .dt_req_o (dt_req_o),
        .dt_i     (dt_i),
        .clk_o    (clk_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .err_o    (err_o)
`ifdef OSC_GEN_CNT_EN
        ,
        .cyc_cnt_o(cyc_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk_i);
        #1;
    endtask

    // Bit i of each pattern is the expected value after the (i+1)-th edge.
    task automatic checkRun(input string tag, input int n, input logic [31:0] clk_pat,
                            input logic [31:0] rise_pat, input logic [31:0] fall_pat);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            checkOutput($sformatf("%s clk %0d", tag, i), {31'd0, clk_o}, {31'd0, clk_pat[i]});
            checkOutput($sformatf("%s rise %0d", tag, i), {31'd0, rise_o}, {31'd0, rise_pat[i]});
            checkOutput($sformatf("%s fall %0d", tag, i), {31'd0, fall_o}, {31'd0, fall_pat[i]});
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        en_i     = 1'b1;
        t_lo_i   = 32'd3;
        t_hi_i   = 32'd5;
        follow   = 1'b0;
        dt_drive = 32'd1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst clk", {31'd0, clk_o}, 32'd0);
        checkOutput("rst rise", {31'd0, rise_o}, 32'd0);
        checkOutput("rst fall", {31'd0, fall_o}, 32'd0);
        checkOutput("rst err", {31'd0, err_o}, 32'd0);
        checkOutput("rst dtreq", dt_req_o, 32'hFFFF_FFFF);

        // Granting the full request each edge: 3,5,3,5 with clk_o flipping every cycle.
        rst_ni = 1'b1;
        follow = 1'b1;
        applyStimulus();
        checkOutput("load dtreq", dt_req_o, 32'd3);
        checkOutput("load clk", {31'd0, clk_o}, 32'd0);
        applyStimulus();
        checkOutput("fol1 clk", {31'd0, clk_o}, 32'd1);
        checkOutput("fol1 rise", {31'd0, rise_o}, 32'd1);
        checkOutput("fol1 dtreq", dt_req_o, 32'd5);
        applyStimulus();
        checkOutput("fol2 clk", {31'd0, clk_o}, 32'd0);
        checkOutput("fol2 fall", {31'd0, fall_o}, 32'd1);
        checkOutput("fol2 dtreq", dt_req_o, 32'd3);
        applyStimulus();
        checkOutput("fol3 clk", {31'd0, clk_o}, 32'd1);
        checkOutput("fol3 dtreq", dt_req_o, 32'd5);
        applyStimulus();
        checkOutput("fol4 clk", {31'd0, clk_o}, 32'd0);
        checkOutput("fol4 dtreq", dt_req_o, 32'd3);

        // Unit steps: low 3 cycles, high 5 cycles, two full periods.
        follow   = 1'b0;
        dt_drive = 32'd1;
        checkRun("unit", 16, 32'h7C7C, 32'h0404, 32'h8080);

        // t_hi changes mid-high: this high phase stays 5, the next is 2.
        checkRun("chg a", 4, 32'hC, 32'h4, 32'h0);
        t_hi_i = 32'd2;
        checkRun("chg b", 9, 32'h0C7, 32'h040, 32'h108);
        checkOutput("chg dtreq", dt_req_o, 32'd3);
        t_hi_i = 32'd5;

        // Overrun: rem=4 in high phase, grant 7.
        checkRun("pre ovr", 4, 32'hC, 32'h4, 32'h0);
        checkOutput("pre ovr dtreq", dt_req_o, 32'd4);
        checkOutput("pre ovr err", {31'd0, err_o}, 32'd0);
        dt_drive = 32'd7;
        applyStimulus();
        checkOutput("ovr err", {31'd0, err_o}, 32'd1);
        checkOutput("ovr clk", {31'd0, clk_o}, 32'd0);
        checkOutput("ovr fall", {31'd0, fall_o}, 32'd1);
        checkOutput("ovr rise", {31'd0, rise_o}, 32'd0);
        checkOutput("ovr dtreq", dt_req_o, 32'd3);
        dt_drive = 32'd1;
        applyStimulus();
        checkOutput("post ovr err", {31'd0, err_o}, 32'd1);
        checkOutput("post ovr clk", {31'd0, clk_o}, 32'd0);
        checkOutput("post ovr dtreq", dt_req_o, 32'd2);

        // Zero low duration clamps to a single unit.
        checkRun("pre zero", 2, 32'h2, 32'h2, 32'h0);
        t_lo_i = 32'd0;
        checkRun("hi zero", 4, 32'hF, 32'h0, 32'h0);
        applyStimulus();
        checkOutput("zero clk", {31'd0, clk_o}, 32'd0);
        checkOutput("zero fall", {31'd0, fall_o}, 32'd1);
        checkOutput("zero dtreq", dt_req_o, 32'd1);
        applyStimulus();
        checkOutput("zero end clk", {31'd0, clk_o}, 32'd1);
        checkOutput("zero end rise", {31'd0, rise_o}, 32'd1);
        checkOutput("zero end dtreq", dt_req_o, 32'd5);

        // A zero grant changes nothing.
        dt_drive = 32'd0;
        applyStimulus();
        checkOutput("dt0 clk", {31'd0, clk_o}, 32'd1);
        checkOutput("dt0 rise", {31'd0, rise_o}, 32'd0);
        checkOutput("dt0 dtreq", dt_req_o, 32'd5);

        // Disabled: request is all-ones and nothing moves.
        dt_drive = 32'd1;
        en_i     = 1'b0;
        #1;
        checkOutput("dis dtreq", dt_req_o, 32'hFFFF_FFFF);
        applyStimulus();
        checkOutput("dis clk", {31'd0, clk_o}, 32'd1);
        checkOutput("dis rise", {31'd0, rise_o}, 32'd0);
        checkOutput("dis fall", {31'd0, fall_o}, 32'd0);
        en_i = 1'b1;
        #1;
        checkOutput("reen dtreq", dt_req_o, 32'd5);

        // Mid-phase asynchronous reset.
        applyStimulus();
        checkOutput("mid dtreq", dt_req_o, 32'd4);
        rst_ni = 1'b0;
        #1;
        checkOutput("arst clk", {31'd0, clk_o}, 32'd0);
        checkOutput("arst err", {31'd0, err_o}, 32'd0);
        checkOutput("arst rise", {31'd0, rise_o}, 32'd0);
        checkOutput("arst fall", {31'd0, fall_o}, 32'd0);
        checkOutput("arst dtreq", dt_req_o, 32'hFFFF_FFFF);
        t_lo_i = 32'd3;
        applyStimulus();
        rst_ni = 1'b1;
        applyStimulus();
        checkOutput("reload dtreq", dt_req_o, 32'd3);
        checkOutput("reload clk", {31'd0, clk_o}, 32'd0);
`ifdef OSC_GEN_CNT_EN
        checkOutput("cnt rst", cyc_cnt_o, 32'd0);
        follow = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
        end
        checkOutput("cnt 10", cyc_cnt_o, 32'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
